// File: rtl/game_flow_ctrl.sv
// Rally sequencer: START/SERVE/PLAY/END flow, landing detection, scoring and match win.
// Optional WIN_BY_TWO_EN macro switches the win rule to "reach WIN_SCORE and lead by two".
module game_flow_ctrl #(
  parameter int SERVE_CYCLES = 50_000_000,
  parameter int WIN_SCORE    = 15,
  parameter int GROUND_Y     = 220,
  parameter int BALL_W       = 30,
  parameter int NET_CX       = 163
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic [11:0] ball_x,
  input  logic [11:0] ball_y,
  output logic [1:0]  game_state,
  output logic        who_win,
  output logic [3:0]  player_score,
  output logic [3:0]  npc_score,
  output logic        point_pulse
);

  localparam int CNT_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SERVE_CYCLES - 1);
  localparam logic [12:0]      GROUND_13 = 13'(GROUND_Y);
  localparam logic [12:0]      BALL_W_13 = 13'(BALL_W);
  localparam logic [12:0]      HALF_W_13 = 13'(BALL_W / 2);
  localparam logic [12:0]      NET_CX_13 = 13'(NET_CX);
  localparam logic [3:0]       WIN_4     = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_END   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             guard_q, guard_d;
  logic [3:0]       player_q, player_d;
  logic [3:0]       npc_q, npc_d;
  logic             who_q, who_d;
  logic             pulse_q, pulse_d;
  logic             start_btn_q;

  logic             start_edge;
  logic             landed;
  logic             left_court;
  logic [12:0]      ball_bottom;
  logic [12:0]      ball_cx;
  logic [3:0]       scorer_new;
  logic             match_won;
`ifdef WIN_BY_TWO_EN
  logic [3:0]       other_score;
`endif

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    sat_inc = (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

`ifdef WIN_BY_TWO_EN
  // Score 15 always ends the match so a deuce run cannot stall at the saturation cap.
  function automatic logic wins(input logic [3:0] mine, input logic [3:0] other);
    wins = (mine == 4'hF) ||
           ((mine >= WIN_4) && ({1'b0, mine} >= ({1'b0, other} + 5'd2)));
  endfunction
`else
  function automatic logic wins(input logic [3:0] mine);
    wins = (mine == WIN_4);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_START;
      cnt_q       <= '0;
      guard_q     <= 1'b0;
      player_q    <= 4'd0;
      npc_q       <= 4'd0;
      who_q       <= 1'b0;
      pulse_q     <= 1'b0;
      start_btn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      guard_q     <= guard_d;
      player_q    <= player_d;
      npc_q       <= npc_d;
      who_q       <= who_d;
      pulse_q     <= pulse_d;
      start_btn_q <= start_btn;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    guard_d     = guard_q;
    player_d    = player_q;
    npc_d       = npc_q;
    who_d       = who_q;
    pulse_d     = 1'b0;

    start_edge  = start_btn & ~start_btn_q;
    ball_bottom = {1'b0, ball_y} + BALL_W_13;
    ball_cx     = {1'b0, ball_x} + HALF_W_13;
    landed      = (ball_bottom >= GROUND_13);
    left_court  = (ball_cx < NET_CX_13);
    scorer_new  = left_court ? sat_inc(player_q) : sat_inc(npc_q);
`ifdef WIN_BY_TWO_EN
    other_score = left_court ? npc_q : player_q;
    match_won   = wins(scorer_new, other_score);
`else
    match_won   = wins(scorer_new);
`endif

    case (state_q)
      ST_START: begin
        if (start_edge) begin
          state_d  = ST_SERVE;
          cnt_d    = '0;
          player_d = 4'd0;
          npc_d    = 4'd0;
          who_d    = 1'b0;
        end
      end
      ST_SERVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_PLAY;
          guard_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PLAY: begin
        // First PLAY cycle skips the landing check while the ball position settles.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (landed) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
          if (left_court) begin
            player_d = scorer_new;
            who_d    = 1'b0;
          end else begin
            npc_d = scorer_new;
            who_d = 1'b1;
          end
          state_d = match_won ? ST_END : ST_SERVE;
        end
      end
      ST_END: begin
        if (start_edge) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  assign game_state   = state_q;
  assign who_win      = who_q;
  assign player_score = player_q;
  assign npc_score    = npc_q;
  assign point_pulse  = pulse_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with SERVE_CYCLES=4, WIN_SCORE=3; point results
// are queued when a landing is driven and checked when point_pulse appears.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_btn;
  logic [11:0] ball_x;
  logic [11:0] ball_y;
  logic [1:0]  game_state;
  logic        who_win;
  logic [3:0]  player_score;
  logic [3:0]  npc_score;
  logic        point_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic       who;
    logic [3:0] p;
    logic [3:0] n;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];

`ifdef WIN_BY_TWO_EN
  localparam logic [1:0] ST_AFTER_3_2 = 2'd1;
  localparam logic [3:0] FINAL_P      = 4'd4;
`else
  localparam logic [1:0] ST_AFTER_3_2 = 2'd3;
  localparam logic [3:0] FINAL_P      = 4'd3;
`endif

  game_flow_ctrl #(
    .SERVE_CYCLES(4),
    .WIN_SCORE   (3),
    .GROUND_Y    (220),
    .BALL_W      (30),
    .NET_CX      (163)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_btn   (start_btn),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .game_state  (game_state),
    .who_win     (who_win),
    .player_score(player_score),
    .npc_score   (npc_score),
    .point_pulse (point_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Remaining SERVE cycles after the entry edge, then the move into PLAY.
  task automatic serve_wait(input logic poke_start);
    for (int i = 0; i < 3; i++) begin
      start_btn = poke_start && (i == 0);
      tick();
      chk("serve_hold", game_state, 2'd1);
      chk("serve_pulse", point_pulse, 1'b0);
    end
    start_btn = 1'b0;
    tick();
    chk("serve_to_play", game_state, 2'd2);
  endtask

  // Guard cycle with a landing already present: no point may be awarded.
  task automatic guard_cycle(input logic [11:0] x, input logic [11:0] y);
    ball_x = x;
    ball_y = y;
    tick();
    chk("guard_state", game_state, 2'd2);
    chk("guard_pulse", point_pulse, 1'b0);
  endtask

  task automatic land(input logic [11:0] x, input logic [11:0] y, input logic who,
                      input logic [3:0] p, input logic [3:0] n, input logic [1:0] st);
    exp_t e;
    int   waited;
    e.who = who; e.p = p; e.n = n; e.st = st;
    ball_x = x;
    ball_y = y;
    exp_q.push_back(e);
    waited = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      waited++;
      if (point_pulse === 1'b1) break;
    end
    chk("land_latency", waited, 1);
    if (point_pulse === 1'b1) begin
      e = exp_q.pop_front();
      chk("land_who", who_win, e.who);
      chk("land_player", player_score, e.p);
      chk("land_npc", npc_score, e.n);
      chk("land_state", game_state, e.st);
    end else begin
      chk("land_pulse", point_pulse, 1'b1);
      void'(exp_q.pop_front());
    end
    ball_y = 12'd0;
  endtask

  initial begin
    reset_n   = 1'b0;
    start_btn = 1'b0;
    ball_x    = 12'd0;
    ball_y    = 12'd0;
    repeat (3) tick();
    chk("rst_state", game_state, 2'd0);
    chk("rst_who", who_win, 1'b0);
    chk("rst_player", player_score, 4'd0);
    chk("rst_npc", npc_score, 4'd0);
    chk("rst_pulse", point_pulse, 1'b0);

    reset_n = 1'b1;
    tick();
    chk("idle_start", game_state, 2'd0);
    start_btn = 1'b1;
    tick();
    chk("start_to_serve", game_state, 2'd1);
    start_btn = 1'b0;
    serve_wait(1'b1);
    chk("serve_player", player_score, 4'd0);
    chk("serve_who", who_win, 1'b0);

    // Player point, left court.
    guard_cycle(12'd40, 12'd200);
    land(12'd40, 12'd200, 1'b0, 4'd1, 4'd0, 2'd1);
    serve_wait(1'b0);

    // Ball one pixel short of the ground never lands, then NPC point.
    ball_x = 12'd200;
    ball_y = 12'd189;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noland_state", game_state, 2'd2);
      chk("noland_pulse", point_pulse, 1'b0);
    end
    land(12'd200, 12'd190, 1'b1, 4'd1, 4'd1, 2'd1);
    serve_wait(1'b0);

    // cx = 162 is still left court.
    guard_cycle(12'd147, 12'd220);
    land(12'd147, 12'd220, 1'b0, 4'd2, 4'd1, 2'd1);
    serve_wait(1'b0);

    // cx = 163 is right court.
    guard_cycle(12'd148, 12'd210);
    land(12'd148, 12'd210, 1'b1, 4'd2, 4'd2, 2'd1);
    serve_wait(1'b0);

    guard_cycle(12'd40, 12'd200);
    land(12'd40, 12'd200, 1'b0, 4'd3, 4'd2, ST_AFTER_3_2);
`ifdef WIN_BY_TWO_EN
    serve_wait(1'b0);
    guard_cycle(12'd40, 12'd200);
    land(12'd40, 12'd200, 1'b0, 4'd4, 4'd2, 2'd3);
`endif

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("end_hold", game_state, 2'd3);
      chk("end_pulse", point_pulse, 1'b0);
    end
    start_btn = 1'b1;
    tick();
    chk("end_to_start", game_state, 2'd0);
    chk("start_held_player", player_score, FINAL_P);
    chk("start_held_npc", npc_score, 4'd2);
    start_btn = 1'b0;
    tick();
    chk("start_idle", game_state, 2'd0);
    start_btn = 1'b1;
    tick();
    chk("restart_state", game_state, 2'd1);
    chk("restart_player", player_score, 4'd0);
    chk("restart_npc", npc_score, 4'd0);
    chk("restart_who", who_win, 1'b0);
    start_btn = 1'b0;
    serve_wait(1'b0);

    guard_cycle(12'd40, 12'd200);
    land(12'd40, 12'd200, 1'b0, 4'd1, 4'd0, 2'd1);
    serve_wait(1'b0);

    // Reset during PLAY, with a start edge in the same cycle.
    ball_y    = 12'd200;
    reset_n   = 1'b0;
    start_btn = 1'b1;
    tick();
    chk("play_rst_state", game_state, 2'd0);
    chk("play_rst_player", player_score, 4'd0);
    chk("play_rst_pulse", point_pulse, 1'b0);
    reset_n   = 1'b1;
    start_btn = 1'b0;
    tick();
    chk("post_rst_state", game_state, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
